// File: rtl/vending_machine_change.sv
// vending_machine_change
//
// Vending controller with a configurable price, three coin denominations,
// change return and cancel/refund. Credit builds up one coin per cycle from
// the coin acceptor. When it reaches PRICE, dispense pulses for one cycle.
// Any remainder, or the whole credit on cancel, is then paid back one coin
// per cycle, largest denomination first.
//
// Parameters
//   PRICE     item price in cents (multiple of 5, >= 5)
//   CREDIT_W  credit register width (PRICE + 20 < 2**CREDIT_W)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   coin         coin inserted this cycle: 00 none, 01 = 5, 10 = 10, 11 = 25
//   cancel       refund request, sampled every cycle (ignored while paying out)
//   dispense     one-cycle product-release pulse
//   change_coin  coin paid out this cycle, same encoding as coin
//   coin_reject  one-cycle pulse: the coin sampled on the previous edge was refused
//   busy         high while paying out change or a refund
//   credit       current credit in cents
//
// State table
//   state   | meaning
//   COLLECT | accepting coins; vend on reaching PRICE, refund on cancel
//   CHANGE  | paying credit back greedily, one coin per cycle; coins refused

module vending_machine_change #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic {
    COLLECT = 1'b0,
    CHANGE  = 1'b1
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_5    = 2'b01;
  localparam logic [1:0] CODE_10   = 2'b10;
  localparam logic [1:0] CODE_25   = 2'b11;

  localparam logic [CREDIT_W-1:0] VAL_5    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] VAL_10   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] VAL_25   = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] PRICE_W  = CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] pay_val;
  logic [1:0]          pay_code;

  // Value of the coin presented this cycle.
  always_comb begin
    coin_val = '0;
    case (coin)
      CODE_5:  coin_val = VAL_5;
      CODE_10: coin_val = VAL_10;
      CODE_25: coin_val = VAL_25;
      default: coin_val = '0;
    endcase
  end

  // The parameter constraint keeps credit + 25 within CREDIT_W bits.
  assign sum = credit + coin_val;

  // Greedy payout: the largest denomination that still fits in the credit.
  // Credit is always a multiple of 5, so this never leaves a stranded residue.
  always_comb begin
    pay_val  = '0;
    pay_code = CODE_NONE;
    if (credit >= VAL_25) begin
      pay_val  = VAL_25;
      pay_code = CODE_25;
    end else if (credit >= VAL_10) begin
      pay_val  = VAL_10;
      pay_code = CODE_10;
    end else if (credit >= VAL_5) begin
      pay_val  = VAL_5;
      pay_code = CODE_5;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      dispense    <= 1'b0;
      change_coin <= CODE_NONE;
      coin_reject <= 1'b0;
      credit      <= '0;
    end else begin
      dispense    <= 1'b0;
      change_coin <= CODE_NONE;
      coin_reject <= 1'b0;

      case (state)
        COLLECT: begin
          if (cancel) begin
            // A coin arriving with cancel is refunded along with the credit,
            // even if the total would have bought the item.
            credit <= sum;
            if (sum != '0) state <= CHANGE;
          end else if (sum >= PRICE_W) begin
            dispense <= 1'b1;
            credit   <= sum - PRICE_W;
            if (sum != PRICE_W) state <= CHANGE;
          end else begin
            credit <= sum;
          end
        end

        CHANGE: begin
          change_coin <= pay_code;
          credit      <= credit - pay_val;
          // Leaving here on the last coin makes busy drop while that coin
          // is shown on change_coin.
          if (credit == pay_val) state <= COLLECT;
          if (coin != CODE_NONE) coin_reject <= 1'b1;
        end

        default: state <= COLLECT;
      endcase
    end
  end

  assign busy = (state == CHANGE);

endmodule
